// File: rtl/hdmi_rx_video_decoder.sv
// ---------------------------------------------------------------------------
// hdmi_rx_video_decoder
//
// Receive-side video decoder. Takes a parallel DE/HSYNC/VSYNC stream that
// carries YCbCr 4:2:2 (8-bit Y plus 8-bit time-multiplexed Cb/Cr) and
// rebuilds 4:4:4 pixels tagged with x/y coordinates. It also measures the
// frame geometry and reports whether that geometry is stable (locked).
//
// Ports
//   pixel_clk            pixel clock, every port is synchronous to it
//   reset_n              synchronous reset, ACTIVE-HIGH despite the name
//   in_de                data enable
//   in_hsync / in_vsync  syncs, active level set by HS_POL / VS_POL
//   in_Y                 luma
//   in_Cb_Cr             chroma, Cb on even active pixels, Cr on odd ones
//   out_valid            reconstructed pixel valid (2 clocks after input)
//   out_Y/out_Cb/out_Cr  reconstructed 4:4:4 pixel
//   out_x / out_y        column / active-line index, 0-based
//   out_sof / out_eol    first pixel of frame / last pixel of line
//   h_total / h_active   clocks per line / DE clocks per line
//   v_total / v_active   lines per frame / active lines per frame
//   locked               geometry identical for LOCK_FRAMES frames
//   fmt_err              sticky: a line with an odd number of pixels seen
// ---------------------------------------------------------------------------
module hdmi_rx_video_decoder #(
    parameter int   HW          = 12,
    parameter int   VW          = 11,
    parameter logic HS_POL      = 1'b1,
    parameter logic VS_POL      = 1'b1,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic          pixel_clk,
    input  logic          reset_n,
    input  logic          in_de,
    input  logic          in_hsync,
    input  logic          in_vsync,
    input  logic [7:0]    in_Y,
    input  logic [7:0]    in_Cb_Cr,
    output logic          out_valid,
    output logic [7:0]    out_Y,
    output logic [7:0]    out_Cb,
    output logic [7:0]    out_Cr,
    output logic [HW-1:0] out_x,
    output logic [VW-1:0] out_y,
    output logic          out_sof,
    output logic          out_eol,
    output logic [HW-1:0] h_total,
    output logic [HW-1:0] h_active,
    output logic [VW-1:0] v_total,
    output logic [VW-1:0] v_active,
    output logic          locked,
    output logic          fmt_err
);

    typedef enum logic [1:0] {
        SEARCH,
        CHECK,
        LOCKED
    } lock_state_t;

    localparam logic [3:0] LOCK_TGT       = 4'(LOCK_FRAMES);
    localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [HW-1:0] h_sat_inc(input logic [HW-1:0] v);
        return (&v) ? v : v + HW'(1);
    endfunction

    function automatic logic [VW-1:0] v_sat_inc(input logic [VW-1:0] v);
        return (&v) ? v : v + VW'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Input stage: one register on every input, syncs normalised so that
    // 1 always means "sync active".
    // -----------------------------------------------------------------------
    logic       r_de, r_hs, r_vs;
    logic       r_de_d, r_hs_d, r_vs_d;
    logic [7:0] r_y, r_c;

    always_ff @(posedge pixel_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value no matter the statement order.
        if (reset_n) begin
            r_de   <= 1'b0;
            r_hs   <= 1'b0;
            r_vs   <= 1'b0;
            r_de_d <= 1'b0;
            r_hs_d <= 1'b0;
            r_vs_d <= 1'b0;
            r_y    <= '0;
            r_c    <= '0;
        end else begin
            r_de   <= in_de;
            r_hs   <= (in_hsync == HS_POL);
            r_vs   <= (in_vsync == VS_POL);
            r_de_d <= r_de;
            r_hs_d <= r_hs;
            r_vs_d <= r_vs;
            r_y    <= in_Y;
            r_c    <= in_Cb_Cr;
        end
    end

    logic hs_edge, vs_edge, de_rise, de_fall;

    assign hs_edge = r_hs & ~r_hs_d;
    assign vs_edge = r_vs & ~r_vs_d;
    assign de_rise = r_de & ~r_de_d;
    assign de_fall = ~r_de & r_de_d;

    // Nothing is decoded or measured until the first frame boundary has been
    // seen, so the first partial frame after reset is discarded.
    logic sync_acquired;

    always_ff @(posedge pixel_clk) begin
        if (reset_n) begin
            sync_acquired <= 1'b0;
        end else if (vs_edge) begin
            sync_acquired <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Pixel path. The registered pixel (r_*) is paired with the pixel still
    // on the port: an even pixel borrows its Cr from the port, which keeps
    // the total latency at two clocks.
    // -----------------------------------------------------------------------
    logic          last_odd;
    logic [7:0]    cb_hold;
    logic [HW-1:0] x_cnt;
    logic [VW-1:0] y_cnt;

    logic          pix_odd;
    logic [HW-1:0] pix_x;
    logic [7:0]    pix_cb, pix_cr;
    logic          acq_pix;
    logic          partner_missing;

    assign pix_odd         = de_rise ? 1'b0 : ~last_odd;
    assign pix_x           = de_rise ? '0 : h_sat_inc(x_cnt);
    assign acq_pix         = r_de & sync_acquired;
    // An even pixel whose successor is not DE ends an odd-length line.
    assign partner_missing = ~pix_odd & ~in_de;
    assign pix_cb          = pix_odd ? cb_hold : r_c;
    assign pix_cr          = pix_odd ? r_c : (in_de ? in_Cb_Cr : CHROMA_NEUTRAL);

    always_ff @(posedge pixel_clk) begin
        if (reset_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_Y     <= '0;
            out_Cb    <= '0;
            out_Cr    <= '0;
            out_x     <= '0;
            out_y     <= '0;
            last_odd  <= 1'b0;
            cb_hold   <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            fmt_err   <= 1'b0;
        end else begin
            out_valid <= acq_pix;
            out_sof   <= acq_pix & (pix_x == '0) & (y_cnt == '0);
            out_eol   <= acq_pix & ~in_de;

            if (r_de) begin
                out_Y    <= r_y;
                out_Cb   <= pix_cb;
                out_Cr   <= pix_cr;
                out_x    <= pix_x;
                out_y    <= y_cnt;
                x_cnt    <= pix_x;
                last_odd <= pix_odd;
                if (!pix_odd) begin
                    cb_hold <= r_c;
                end
            end

            if (acq_pix && partner_missing) begin
                fmt_err <= 1'b1;
            end

            // Frame start wins over a coincident end of line.
            if (vs_edge) begin
                y_cnt <= '0;
            end else if (de_fall) begin
                y_cnt <= v_sat_inc(y_cnt);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Geometry measurement. Per-line values land in shadows; the frame
    // boundary copies the most recent completed line plus the line counts.
    // The cand_* terms fold in an hsync edge or DE fall landing on the same
    // clock as the vsync edge, so those count toward the frame that ends.
    // -----------------------------------------------------------------------
    logic [HW-1:0] h_cnt, h_line, de_cnt, de_line;
    logic [VW-1:0] line_cnt, act_cnt;
    logic [HW-1:0] cand_ht, cand_ha;
    logic [VW-1:0] cand_vt, cand_va;

    assign cand_ht = hs_edge ? h_cnt : h_line;
    assign cand_ha = de_fall ? de_cnt : de_line;
    assign cand_vt = hs_edge ? v_sat_inc(line_cnt) : line_cnt;
    assign cand_va = de_fall ? v_sat_inc(act_cnt) : act_cnt;

    always_ff @(posedge pixel_clk) begin
        if (reset_n) begin
            h_cnt    <= '0;
            h_line   <= '0;
            de_cnt   <= '0;
            de_line  <= '0;
            line_cnt <= '0;
            act_cnt  <= '0;
            h_total  <= '0;
            h_active <= '0;
            v_total  <= '0;
            v_active <= '0;
        end else begin
            // h_cnt restarts at 1 so that it equals the line length when the
            // next leading edge arrives.
            if (hs_edge) begin
                h_cnt  <= HW'(1);
                h_line <= h_cnt;
            end else begin
                h_cnt  <= h_sat_inc(h_cnt);
            end

            if (r_de) begin
                de_cnt <= de_rise ? HW'(1) : h_sat_inc(de_cnt);
            end
            if (de_fall) begin
                de_line <= de_cnt;
            end

            if (vs_edge) begin
                line_cnt <= '0;
                act_cnt  <= '0;
            end else begin
                if (hs_edge) begin
                    line_cnt <= v_sat_inc(line_cnt);
                end
                if (de_fall) begin
                    act_cnt <= v_sat_inc(act_cnt);
                end
            end

            if (vs_edge && sync_acquired) begin
                h_total  <= cand_ht;
                h_active <= cand_ha;
                v_total  <= cand_vt;
                v_active <= cand_va;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Lock FSM, evaluated once per frame on the vsync leading edge against
    // the values being latched on that same edge.
    // -----------------------------------------------------------------------
    lock_state_t   state, next_state;
    logic [HW-1:0] st_ht, st_ha;
    logic [VW-1:0] st_vt, st_va;
    logic [3:0]    match_cnt, match_nxt, match_inc;
    logic          store_set;
    logic          eval, any_zero, same_set;

    assign eval      = vs_edge & sync_acquired;
    assign any_zero  = (cand_ht == '0) | (cand_ha == '0) |
                       (cand_vt == '0) | (cand_va == '0);
    assign same_set  = (cand_ht == st_ht) & (cand_ha == st_ha) &
                       (cand_vt == st_vt) & (cand_va == st_va);
    assign match_inc = match_cnt + 4'd1;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        next_state = state;
        match_nxt  = match_cnt;
        store_set  = 1'b0;

        if (eval) begin
            if (any_zero) begin
                next_state = SEARCH;
                match_nxt  = '0;
            end else begin
                case (state)
                    SEARCH: begin
                        store_set  = 1'b1;
                        match_nxt  = 4'd1;
                        next_state = (LOCK_TGT <= 4'd1) ? LOCKED : CHECK;
                    end
                    CHECK: begin
                        if (same_set) begin
                            match_nxt = match_inc;
                            if (match_inc >= LOCK_TGT) begin
                                next_state = LOCKED;
                            end
                        end else begin
                            store_set = 1'b1;
                            match_nxt = 4'd1;
                        end
                    end
                    LOCKED: begin
                        if (!same_set) begin
                            store_set  = 1'b1;
                            match_nxt  = 4'd1;
                            next_state = CHECK;
                        end
                    end
                    default: begin
                        next_state = SEARCH;
                        match_nxt  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset_n) begin
            state     <= SEARCH;
            match_cnt <= '0;
            st_ht     <= '0;
            st_ha     <= '0;
            st_vt     <= '0;
            st_va     <= '0;
        end else begin
            state     <= next_state;
            match_cnt <= match_nxt;
            if (store_set) begin
                st_ht <= cand_ht;
                st_ha <= cand_ha;
                st_vt <= cand_vt;
                st_va <= cand_va;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_hdmi_rx_video_decoder.sv
// ---------------------------------------------------------------------------
// Testbench for hdmi_rx_video_decoder.
// Two instances share the stimulus: dut A with active-high syncs and dut B
// with active-low syncs fed the inverted sync lines. Every driven DE pixel
// pushes its expected 4:4:4 result onto a queue, tagged with the cycle in
// which it must appear; each cycle the outputs of both instances are
// compared against the queue head.
// Frame: 12 (or 14) clocks per line, hsync at columns 0..1, DE from column
// 3; 6 lines, vsync on line 0, active lines 1..4. Line 1 may be shortened.
// ---------------------------------------------------------------------------
module tb_hdmi_rx_video_decoder;

    typedef struct {
        logic [7:0]  y;
        logic [7:0]  cb;
        logic [7:0]  cr;
        logic [11:0] x;
        logic [10:0] yy;
        logic        sof;
        logic        eol;
        int          cyc;
    } exp_t;

    logic pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    logic       reset_n  = 1'b1;
    logic       in_de    = 1'b0;
    logic       hs       = 1'b0;
    logic       vs       = 1'b0;
    logic [7:0] in_Y     = '0;
    logic [7:0] in_Cb_Cr = '0;
    logic       b_hsync, b_vsync;

    assign b_hsync = ~hs;
    assign b_vsync = ~vs;

    logic        a_valid, a_sof, a_eol, a_locked, a_fmt_err;
    logic [7:0]  a_Y, a_Cb, a_Cr;
    logic [11:0] a_x, a_h_total, a_h_active;
    logic [10:0] a_y, a_v_total, a_v_active;

    logic        b_valid, b_sof, b_eol, b_locked, b_fmt_err;
    logic [7:0]  b_Y, b_Cb, b_Cr;
    logic [11:0] b_x, b_h_total, b_h_active;
    logic [10:0] b_y, b_v_total, b_v_active;

    hdmi_rx_video_decoder #(
        .HW(12), .VW(11), .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(2)
    ) dut_a (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .in_de(in_de),
        .in_hsync(hs), .in_vsync(vs), .in_Y(in_Y), .in_Cb_Cr(in_Cb_Cr),
        .out_valid(a_valid), .out_Y(a_Y), .out_Cb(a_Cb), .out_Cr(a_Cr),
        .out_x(a_x), .out_y(a_y), .out_sof(a_sof), .out_eol(a_eol),
        .h_total(a_h_total), .h_active(a_h_active),
        .v_total(a_v_total), .v_active(a_v_active),
        .locked(a_locked), .fmt_err(a_fmt_err)
    );

    hdmi_rx_video_decoder #(
        .HW(12), .VW(11), .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)
    ) dut_b (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .in_de(in_de),
        .in_hsync(b_hsync), .in_vsync(b_vsync), .in_Y(in_Y), .in_Cb_Cr(in_Cb_Cr),
        .out_valid(b_valid), .out_Y(b_Y), .out_Cb(b_Cb), .out_Cr(b_Cr),
        .out_x(b_x), .out_y(b_y), .out_sof(b_sof), .out_eol(b_eol),
        .h_total(b_h_total), .h_active(b_h_active),
        .v_total(b_v_total), .v_active(b_v_active),
        .locked(b_locked), .fmt_err(b_fmt_err)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   model_acq = 1'b0;
    exp_t q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] chroma(input int k);
        return (k % 2 == 0) ? 8'(64 + 16 * (k / 2)) : 8'(192 + 16 * (k / 2));
    endfunction

    task automatic mon_dut(input string p, input bit have, input exp_t e,
                           input logic v, input logic [7:0] oy, ocb, ocr,
                           input logic [11:0] ox, input logic [10:0] oyy,
                           input logic os, oe);
        if (have) begin
            check({p, "valid"}, 32'(v), 32'd1);
            check({p, "Y"},     32'(oy),  32'(e.y));
            check({p, "Cb"},    32'(ocb), 32'(e.cb));
            check({p, "Cr"},    32'(ocr), 32'(e.cr));
            check({p, "x"},     32'(ox),  32'(e.x));
            check({p, "y"},     32'(oyy), 32'(e.yy));
            check({p, "sof"},   32'(os),  32'(e.sof));
            check({p, "eol"},   32'(oe),  32'(e.eol));
        end else if (v) begin
            check({p, "spurious_valid"}, 32'(v), 32'd0);
        end
    endtask

    // One clock: drive after the rising edge, compare on the falling edge.
    task automatic tick(input logic r, input logic d, input logic h, input logic v,
                        input logic [7:0] py, input logic [7:0] pc);
        exp_t e;
        bit   have;
        @(posedge pixel_clk);
        cyc++;
        #1;
        reset_n  = r;
        in_de    = d;
        hs       = h;
        vs       = v;
        in_Y     = py;
        in_Cb_Cr = pc;
        @(negedge pixel_clk);
        have = (q.size() > 0) && (q[0].cyc <= cyc);
        if (have) e = q.pop_front();
        mon_dut("a_", have, e, a_valid, a_Y, a_Cb, a_Cr, a_x, a_y, a_sof, a_eol);
        mon_dut("b_", have, e, b_valid, b_Y, b_Cb, b_Cr, b_x, b_y, b_sof, b_eol);
    endtask

    task automatic check_status(input int ht, input int ha, input int vt, input int va,
                                input logic lk, input logic fe);
        check("a_h_total",  32'(a_h_total),  ht);
        check("a_h_active", 32'(a_h_active), ha);
        check("a_v_total",  32'(a_v_total),  vt);
        check("a_v_active", 32'(a_v_active), va);
        check("a_locked",   32'(a_locked),   32'(lk));
        check("a_fmt_err",  32'(a_fmt_err),  32'(fe));
        check("b_h_total",  32'(b_h_total),  ht);
        check("b_h_active", 32'(b_h_active), ha);
        check("b_v_total",  32'(b_v_total),  vt);
        check("b_v_active", 32'(b_v_active), va);
        check("b_locked",   32'(b_locked),   32'(lk));
        check("b_fmt_err",  32'(b_fmt_err),  32'(fe));
    endtask

    // One frame; ha0 is the pixel count of the first active line, the other
    // active lines have 8. A reset pulse is issued at (rst_line, rst_col).
    task automatic send_frame(input int ht, input int ha0, input int rst_line, input int rst_col);
        int         ha, k;
        logic       d, h, v;
        logic [7:0] py, pc;
        bit         do_rst, zero_pending;
        exp_t       e;
        zero_pending = 1'b0;
        for (int l = 0; l < 6; l++) begin
            for (int cc = 0; cc < ht; cc++) begin
                ha     = (l == 1) ? ha0 : 8;
                k      = cc - 3;
                d      = (l >= 1) && (l <= 4) && (k >= 0) && (k < ha);
                h      = (cc < 2);
                v      = (l == 0);
                py     = d ? 8'(10 + k + 16 * (l - 1)) : 8'h00;
                pc     = d ? chroma(k) : 8'h00;
                do_rst = (l == rst_line) && (cc == rst_col);
                if (l == 0 && cc == 0) model_acq = 1'b1;
                tick(do_rst, d, h, v, py, pc);
                if (zero_pending) begin
                    zero_pending = 1'b0;
                    check("rst_a_valid",    32'(a_valid),    32'd0);
                    check("rst_a_Y",        32'(a_Y),        32'd0);
                    check("rst_a_Cr",       32'(a_Cr),       32'd0);
                    check("rst_a_x",        32'(a_x),        32'd0);
                    check("rst_a_h_total",  32'(a_h_total),  32'd0);
                    check("rst_a_v_active", 32'(a_v_active), 32'd0);
                    check("rst_a_locked",   32'(a_locked),   32'd0);
                    check("rst_a_fmt_err",  32'(a_fmt_err),  32'd0);
                    check("rst_b_locked",   32'(b_locked),   32'd0);
                    check("rst_b_h_total",  32'(b_h_total),  32'd0);
                end
                if (do_rst) begin
                    // Pixels still in flight are flushed by the reset.
                    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
                    model_acq    = 1'b0;
                    zero_pending = 1'b1;
                end else if (d && model_acq) begin
                    e.y   = py;
                    e.x   = 12'(k);
                    e.yy  = 11'(l - 1);
                    e.sof = (k == 0) && (l == 1);
                    e.eol = (k == ha - 1);
                    e.cyc = cyc + 2;
                    if (k % 2 == 0) begin
                        e.cb = pc;
                        e.cr = (k + 1 < ha) ? chroma(k + 1) : 8'h80;
                    end else begin
                        e.cb = chroma(k - 1);
                        e.cr = pc;
                    end
                    q.push_back(e);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("reset_a_valid", 32'(a_valid), 32'd0);
        check("reset_a_Y",     32'(a_Y),     32'd0);
        check("reset_a_sof",   32'(a_sof),   32'd0);
        check("reset_b_valid", 32'(b_valid), 32'd0);
        check_status(0, 0, 0, 0, 1'b0, 1'b0);

        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Acquisition frame with a 4-pixel first line; nothing latched yet.
        send_frame(12, 4, -1, -1);
        check_status(0, 0, 0, 0, 1'b0, 1'b0);
        // First measured frame: CHECK, not yet locked.
        send_frame(12, 8, -1, -1);
        check_status(12, 8, 6, 4, 1'b0, 1'b0);
        // Second matching frame locks; this one carries a 7-pixel line.
        send_frame(12, 7, -1, -1);
        check_status(12, 8, 6, 4, 1'b1, 1'b1);
        // Line length changes to 14; the edge at its start still sees 12.
        send_frame(14, 8, -1, -1);
        check_status(12, 8, 6, 4, 1'b1, 1'b1);
        send_frame(14, 8, -1, -1);
        check_status(14, 8, 6, 4, 1'b0, 1'b1);
        send_frame(14, 8, -1, -1);
        check_status(14, 8, 6, 4, 1'b1, 1'b1);
        // Reset pulse in the middle of an active line.
        send_frame(12, 8, 2, 5);
        check_status(0, 0, 0, 0, 1'b0, 1'b0);
        send_frame(12, 8, -1, -1);
        check_status(0, 0, 0, 0, 1'b0, 1'b0);
        send_frame(12, 8, -1, -1);
        check_status(12, 8, 6, 4, 1'b0, 1'b0);

        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("queue_drain", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hdmi_rx_video_decoder.md
Name: hdmi_rx_video_decoder

Overview:
Receive-side counterpart of the HDMI test-pattern transmitter. Consumes a parallel DE/HSYNC/VSYNC stream carrying YCbCr 4:2:2 (8-bit Y plus 8-bit multiplexed Cb/Cr) and reconstructs 4:4:4 pixels tagged with x/y coordinates. Measures frame geometry and reports a lock status. Sits after the HDMI receiver or loopback, ahead of the HDR processing pipeline.

Parameters:
HW, 12, width of horizontal counters (h_total, h_active, out_x)
VW, 11, width of vertical counters (v_total, v_active, out_y)
HS_POL, 1, active level of in_hsync (1 = active-high)
VS_POL, 1, active level of in_vsync (1 = active-high)
LOCK_FRAMES, 2, consecutive identical frames required before locked is set (range 1..15)

Ports:
pixel_clk  in  1  pixel clock; every input and output is synchronous to it
reset_n  in  1  synchronous reset, active-high (despite the name)
in_de  in  1  data enable
in_hsync  in  1  horizontal sync, polarity per HS_POL
in_vsync  in  1  vertical sync, polarity per VS_POL
in_Y  in  8  luma
in_Cb_Cr  in  8  chroma: Cb on even active pixels, Cr on odd active pixels
out_valid  out  1  output pixel valid
out_Y / out_Cb / out_Cr  out  8 each  reconstructed 4:4:4 pixel
out_x  out  HW  pixel column, 0-based
out_y  out  VW  line index within the active region, 0-based
out_sof  out  1  asserted with pixel (0,0)
out_eol  out  1  asserted with the last pixel of each active line
h_total / h_active  out  HW  latched clocks per line / DE clocks per line
v_total / v_active  out  VW  latched lines per frame / active lines per frame
locked  out  1  geometry stable
fmt_err  out  1  sticky odd-length-line flag

Behaviour:
- Reset: every output is 0; all counters are 0; sync_acquired is 0. Reset takes priority over every other event on the same edge.
- Input stage: all inputs are registered once. Sync polarity is normalised internally. Leading edges are detected on the normalised registered syncs.
- sync_acquired: set on the first vsync leading edge after reset. While it is 0, out_valid stays 0 and measurement registers are not updated. The next full frame is decoded normally.
- Pixel path: fixed latency of 2 clocks. Output cycle n+2 corresponds to the pixel sampled at the port in cycle n.
  - Even pixel k (in_Cb_Cr = Cb): out_Cb = its own Cb, out_Cr = Cr from pixel k+1.
  - Odd pixel k+1: out_Cb = Cb from pixel k, out_Cr = its own Cr.
  - out_Y is always the pixel's own Y.
- Chroma phase: resets to even at every DE rising edge.
- Odd-length line: the final even pixel has no partner, so out_Cr = 8'h80. fmt_err is set and holds until reset.
- out_x: 0 on the first DE pixel of a line; increments by 1 per DE pixel.
- out_y: 0 for the first active line after a vsync leading edge; increments on each DE falling edge.
- Counters saturate at all-ones and never wrap.
- out_eol: asserted on the output pixel whose port-side successor cycle had in_de = 0.
- out_sof: asserted when out_x = 0 and out_y = 0 with out_valid = 1.
- out_valid: registered in_de delayed 2 clocks, gated by sync_acquired.
- Measurement:
  - h_cnt counts clocks between hsync leading edges; it is copied to a per-line h_total shadow at each hsync edge.
  - de_cnt counts DE clocks per line.
  - The line counter counts hsync leading edges per frame; the active-line counter counts DE falling edges.
  - At each vsync leading edge, the last completed line's values and the frame's line counts are latched into h_total, h_active, v_total and v_active.
- Lock FSM: states SEARCH, CHECK, LOCKED. Evaluated only at vsync leading edges.
  - SEARCH to CHECK: all four measurements are nonzero. Store them; match_cnt = 1.
  - CHECK, measurements equal the stored set: match_cnt++. Reaching LOCK_FRAMES moves to LOCKED with locked = 1.
  - CHECK, any measurement differs: store the new set, match_cnt = 1, stay in CHECK.
  - LOCKED, any measurement differs: locked = 0 on that same edge, go to CHECK with the new set.
  - Any zero measurement sends the FSM to SEARCH.
  - With LOCK_FRAMES = 1, the FSM goes straight to LOCKED from the first valid frame.
- Simultaneous hsync and vsync leading edges: the line counters update first, then the vsync latch captures the updated values.

Test Plan:
- Frame: 8 active x 4 active, h_total 12, v_total 6, two full frames -> h_active=8, h_total=12, v_active=4, v_total=6. locked=1 at the second vsync edge following acquisition.
- Line: Y=10,11,12,13, Cb_Cr=0x40,0xC0,0x50,0xD0 -> pixels (10,40,C0), (11,40,C0), (12,50,D0), (13,50,D0). Each appears 2 clocks after input; x=0..3; eol on the 4th pixel.
- 7-pixel line -> the 7th pixel has out_Cr=0x80. fmt_err=1 and stays 1 across subsequent good lines.
- Locked stream, then h_total changes to 14 -> locked=0 at the next vsync edge. locked returns to 1 after LOCK_FRAMES matching frames.
- reset_n pulse mid-line -> the next edge sees all outputs 0. out_valid stays 0 until a vsync leading edge, then sof is seen at (0,0).
- HS_POL=0, VS_POL=0 with inverted sync stimulus -> measurements and pixels identical to scenario 1.
